// File: rtl/alu_issue_unit.sv
// Issue-side controller for the single-cycle ALU: encodes the request, drives
// registered operands/opcode into the ALU, then captures and returns the result.
module alu_issue_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_aluop,
    input  logic [2:0]        req_funct3,
    input  logic              req_funct7b5,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic [DATA_W-1:0] SrcA,
    output logic [DATA_W-1:0] SrcB,
    output logic [3:0]        Operation,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic              zero,
    input  logic              negative,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_taken,
    output logic              rsp_illegal
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE} branch_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;

    state_t            state_q, state_d;
    branch_t           branch_q, branch_d;
    logic [DATA_W-1:0] srcA_q, srcA_d;
    logic [DATA_W-1:0] srcB_q, srcB_d;
    logic [3:0]        op_q, op_d;
    logic              illegal_q, illegal_d;
    logic              aSign_q, aSign_d;
    logic              bSign_q, bSign_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              taken_q, taken_d;
    logic              rspIllegal_q, rspIllegal_d;
    logic              rspValid_q, rspValid_d;
    logic              negative_unused_q;

    logic [3:0]        encOp;
    branch_t           encBranch;
    logic              encIllegal;
    logic              lessThan;
    logic              takenNow;

    always_comb begin
        encOp      = OP_AND;
        encBranch  = BR_NONE;
        encIllegal = 1'b0;
        unique case (req_aluop)
            2'b00: encOp = OP_ADD;
            2'b01: begin
                encOp = OP_SUB;
                case (req_funct3)
                    3'b000:  encBranch = BR_EQ;
                    3'b001:  encBranch = BR_NE;
                    3'b100:  encBranch = BR_LT;
                    3'b101:  encBranch = BR_GE;
                    default: encIllegal = 1'b1;
                endcase
            end
            2'b10: begin
                case (req_funct3)
                    3'b000:  encOp = req_funct7b5 ? OP_SUB : OP_ADD;
                    3'b100:  encOp = OP_XOR;
                    3'b110:  encOp = OP_OR;
                    3'b111:  encOp = OP_AND;
                    default: encIllegal = 1'b1;
                endcase
            end
            default: encIllegal = 1'b1;
        endcase
        if (encIllegal) begin
            encOp     = OP_AND;
            encBranch = BR_NONE;
        end
    end

    // Signed less-than from the subtract result, corrected when operand signs differ
    // so that overflow of a-b cannot flip the decision.
    assign lessThan = (aSign_q != bSign_q) ? aSign_q : ALUResult[DATA_W-1];

    always_comb begin
        case (branch_q)
            BR_EQ:   takenNow = zero;
            BR_NE:   takenNow = !zero;
            BR_LT:   takenNow = lessThan;
            BR_GE:   takenNow = !lessThan;
            default: takenNow = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        srcA_d       = srcA_q;
        srcB_d       = srcB_q;
        op_d         = op_q;
        branch_d     = branch_q;
        illegal_d    = illegal_q;
        aSign_d      = aSign_q;
        bSign_d      = bSign_q;
        result_d     = result_q;
        taken_d      = taken_q;
        rspIllegal_d = rspIllegal_q;
        rspValid_d   = rspValid_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    srcA_d    = req_a;
                    srcB_d    = req_b;
                    op_d      = encOp;
                    branch_d  = encBranch;
                    illegal_d = encIllegal;
                    aSign_d   = req_a[DATA_W-1];
                    bSign_d   = req_b[DATA_W-1];
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                result_d     = illegal_q ? '0 : ALUResult;
                taken_d      = illegal_q ? 1'b0 : takenNow;
                rspIllegal_d = illegal_q;
                rspValid_d   = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rspValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            srcA_q            <= '0;
            srcB_q            <= '0;
            op_q              <= OP_AND;
            branch_q          <= BR_NONE;
            illegal_q         <= 1'b0;
            aSign_q           <= 1'b0;
            bSign_q           <= 1'b0;
            result_q          <= '0;
            taken_q           <= 1'b0;
            rspIllegal_q      <= 1'b0;
            rspValid_q        <= 1'b0;
            negative_unused_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            srcA_q            <= srcA_d;
            srcB_q            <= srcB_d;
            op_q              <= op_d;
            branch_q          <= branch_d;
            illegal_q         <= illegal_d;
            aSign_q           <= aSign_d;
            bSign_q           <= bSign_d;
            result_q          <= result_d;
            taken_q           <= taken_d;
            rspIllegal_q      <= rspIllegal_d;
            rspValid_q        <= rspValid_d;
            negative_unused_q <= negative;
        end
    end

    assign req_ready   = (state_q == IDLE) && !reset;
    assign SrcA        = srcA_q;
    assign SrcB        = srcB_q;
    assign Operation   = op_q;
    assign rsp_valid   = rspValid_q;
    assign rsp_result  = result_q;
    assign rsp_taken   = taken_q;
    assign rsp_illegal = rspIllegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: behavioural ALU plus a reference model
// derived from the instruction semantics, driven by directed and random requests.
module tb_alu_issue_unit;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_aluop;
    logic [2:0]        req_funct3;
    logic              req_funct7b5;
    logic [DATA_W-1:0] req_a, req_b;
    logic [DATA_W-1:0] SrcA, SrcB;
    logic [3:0]        Operation;
    logic [DATA_W-1:0] ALUResult;
    logic              zero, negative;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_taken, rsp_illegal;

    int checks = 0;
    int errors = 0;

    alu_issue_unit #(.DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_aluop(req_aluop), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
        .req_a(req_a), .req_b(req_b),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .ALUResult(ALUResult), .zero(zero), .negative(negative),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    // Behavioural single-cycle ALU fed by the unit's registered outputs.
    always_comb begin
        case (Operation)
            4'b0000: ALUResult = SrcA & SrcB;
            4'b0001: ALUResult = SrcA | SrcB;
            4'b0010: ALUResult = SrcA + SrcB;
            4'b0011: ALUResult = SrcA ^ SrcB;
            4'b0110: ALUResult = SrcA - SrcB;
            default: ALUResult = 32'hDEADBEEF;
        endcase
    end
    assign zero     = (ALUResult == '0);
    assign negative = ALUResult[DATA_W-1];

    function automatic void refModel(input logic [1:0] aluop, input logic [2:0] f3, input logic b5,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [3:0] op, output logic [31:0] res,
                                     output logic taken, output logic illegal);
        op = 4'd0; res = '0; taken = 1'b0; illegal = 1'b0;
        if (aluop == 2'd0) begin
            op = 4'd2; res = a + b;
        end else if (aluop == 2'd1) begin
            op = 4'd6; res = a - b;
            if (f3 == 3'd0)      taken = (a == b);
            else if (f3 == 3'd1) taken = (a != b);
            else if (f3 == 3'd4) taken = ($signed(a) < $signed(b));
            else if (f3 == 3'd5) taken = ($signed(a) >= $signed(b));
            else                 illegal = 1'b1;
        end else if (aluop == 2'd2) begin
            if (f3 == 3'd0) begin
                if (b5) begin op = 4'd6; res = a - b; end
                else    begin op = 4'd2; res = a + b; end
            end
            else if (f3 == 3'd4) begin op = 4'd3; res = a ^ b; end
            else if (f3 == 3'd6) begin op = 4'd1; res = a | b; end
            else if (f3 == 3'd7) begin op = 4'd0; res = a & b; end
            else illegal = 1'b1;
        end else begin
            illegal = 1'b1;
        end
        if (illegal) begin
            op = 4'd0; res = '0; taken = 1'b0;
        end
    endfunction

    // Runs one full transaction from a negedge, returning what the DUT showed and
    // whether the handshake timing (accept, N+2 response, retire) behaved.
    task automatic runTxn(input logic [1:0] aluop, input logic [2:0] f3, input logic b5,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit earlyReady, input int holdCycles,
                          output logic [3:0] obsOp, output logic [31:0] obsRes,
                          output logic obsTaken, output logic obsIllegal, output bit handshakeOk);
        int n;
        handshakeOk = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) handshakeOk = 1'b0;
        req_aluop = aluop; req_funct3 = f3; req_funct7b5 = b5; req_a = a; req_b = b;
        req_valid = 1'b1;
        rsp_ready = earlyReady;
        @(negedge clk);
        req_valid = 1'b0;
        obsOp = Operation;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) handshakeOk = 1'b0;
        @(negedge clk);
        if (rsp_valid !== 1'b1) handshakeOk = 1'b0;
        obsRes = rsp_result; obsTaken = rsp_taken; obsIllegal = rsp_illegal;
        if (!earlyReady) begin
            repeat (holdCycles) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_result !== obsRes || rsp_taken !== obsTaken ||
                    rsp_illegal !== obsIllegal || req_ready !== 1'b0) handshakeOk = 1'b0;
            end
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) handshakeOk = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] aluop, input logic [2:0] f3, input logic b5,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit earlyReady, input int holdCycles, input string tag);
        logic [3:0]  eOp, oOp;
        logic [31:0] eRes, oRes;
        logic        eTaken, oTaken, eIll, oIll;
        bit          hs;
        refModel(aluop, f3, b5, a, b, eOp, eRes, eTaken, eIll);
        runTxn(aluop, f3, b5, a, b, earlyReady, holdCycles, oOp, oRes, oTaken, oIll, hs);
        checks++;
        if (hs !== 1'b1) begin
            errors++; $display("[TB] FAIL %s handshake: got %0d expected 1", tag, hs);
        end
        checks++;
        if (oOp !== eOp) begin
            errors++; $display("[TB] FAIL %s Operation: got %b expected %b", tag, oOp, eOp);
        end
        checks++;
        if (oRes !== eRes) begin
            errors++; $display("[TB] FAIL %s rsp_result: got %h expected %h", tag, oRes, eRes);
        end
        checks++;
        if (oTaken !== eTaken) begin
            errors++; $display("[TB] FAIL %s rsp_taken: got %b expected %b", tag, oTaken, eTaken);
        end
        checks++;
        if (oIll !== eIll) begin
            errors++; $display("[TB] FAIL %s rsp_illegal: got %b expected %b", tag, oIll, eIll);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_aluop = '0; req_funct3 = '0; req_funct7b5 = 1'b0; req_a = '0; req_b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset ready/valid: got %b/%b expected 0/0", req_ready, rsp_valid);
        end
        checks++;
        if ({SrcA, SrcB, Operation, rsp_result, rsp_taken, rsp_illegal} !== '0) begin
            errors++; $display("[TB] FAIL reset outputs: got %h %h %b %h %b %b expected all zero",
                               SrcA, SrcB, Operation, rsp_result, rsp_taken, rsp_illegal);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL ready after reset: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_directed();
        applyStimulus(2'b10, 3'b000, 1'b0, 32'd5, 32'd7, 1'b0, 0, "add");
        applyStimulus(2'b10, 3'b000, 1'b1, 32'd3, 32'd5, 1'b0, 1, "sub");
        applyStimulus(2'b10, 3'b100, 1'b0, 32'hF0F0, 32'hFF00, 1'b0, 0, "xor");
        applyStimulus(2'b10, 3'b110, 1'b0, 32'hF0F0, 32'h0F0F, 1'b0, 0, "or");
        applyStimulus(2'b10, 3'b111, 1'b0, 32'hF0F0, 32'hFF00, 1'b0, 0, "and");
        applyStimulus(2'b00, 3'b011, 1'b1, 32'h1000, 32'h24, 1'b0, 0, "addr");
        applyStimulus(2'b01, 3'b000, 1'b0, 32'h1234, 32'h1234, 1'b0, 0, "beq");
        applyStimulus(2'b01, 3'b001, 1'b0, 32'h1234, 32'h1234, 1'b0, 0, "bne");
        applyStimulus(2'b01, 3'b100, 1'b0, 32'h80000000, 32'd1, 1'b0, 0, "blt_ovf");
        applyStimulus(2'b01, 3'b101, 1'b0, 32'd1, 32'h80000000, 1'b0, 0, "bge_ovf");
        applyStimulus(2'b10, 3'b010, 1'b0, 32'd9, 32'd9, 1'b0, 0, "ill_f3");
        applyStimulus(2'b11, 3'b000, 1'b0, 32'd9, 32'd9, 1'b0, 0, "ill_op");
        applyStimulus(2'b01, 3'b010, 1'b0, 32'd9, 32'd9, 1'b0, 0, "ill_br");
        applyStimulus(2'b10, 3'b000, 1'b0, 32'd11, 32'd22, 1'b1, 0, "early_ready");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 4) == 0) a = 32'h80000000;
            applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  eOp;
        logic [31:0] eRes;
        logic        eTaken, eIll;
        refModel(2'b10, 3'b000, 1'b0, 32'd100, 32'd23, eOp, eRes, eTaken, eIll);
        req_aluop = 2'b10; req_funct3 = 3'b000; req_funct7b5 = 1'b0; req_a = 32'd100; req_b = 32'd23;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        req_aluop = 2'b10; req_funct3 = 3'b100; req_a = 32'h5555; req_b = 32'h1;
        req_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== eRes || rsp_taken !== eTaken ||
                rsp_illegal !== eIll || req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL backpressure cycle %0d: got v=%b r=%h t=%b i=%b rdy=%b expected v=1 r=%h t=%b i=%b rdy=0",
                         c, rsp_valid, rsp_result, rsp_taken, rsp_illegal, req_ready, eRes, eTaken, eIll);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL backpressure release: got rdy=%b v=%b expected 1/0", req_ready, rsp_valid);
        end
        checks++;
        if (SrcA !== 32'd100 || Operation !== eOp) begin
            errors++; $display("[TB] FAIL second request accepted: got SrcA=%h op=%b expected %h/%b",
                               SrcA, Operation, 32'd100, eOp);
        end
    endtask

    task automatic test_reset_in_exec();
        bit sawValid;
        req_aluop = 2'b10; req_funct3 = 3'b000; req_funct7b5 = 1'b0; req_a = 32'd40; req_b = 32'd2;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({SrcA, SrcB, Operation, rsp_result, rsp_taken, rsp_illegal, rsp_valid, req_ready} !== '0) begin
            errors++; $display("[TB] FAIL reset in EXEC outputs: got %h %h %b %h %b %b %b %b expected all zero",
                               SrcA, SrcB, Operation, rsp_result, rsp_taken, rsp_illegal, rsp_valid, req_ready);
        end
        reset = 1'b0;
        sawValid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) sawValid = 1'b1;
        end
        checks++;
        if (sawValid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL dropped txn: got rsp_valid seen=%b rdy=%b expected 0/1", sawValid, req_ready);
        end
        applyStimulus(2'b01, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, 0, "after_reset");
    endtask

    task automatic checkOutput();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_in_exec();
        checkOutput();
        $finish;
    end

endmodule
